// File: rtl/deser5_pkg.sv
// Shared definitions for the 5-bit serial deserializer: widths, FSM encoding
// and the even-parity check used when a frame closes.
package deser5_pkg;

    localparam int WORD_W = 5;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    // High when data bits plus the parity bit hold an odd number of ones.
    function automatic logic even_par_err(input logic [WORD_W-1:0] data, input logic par_bit);
        return (^data) ^ par_bit;
    endfunction

endpackage

// File: rtl/deser5bit_if.sv
// Bus bundle between the serial source and the deserializer: serial bit
// stream in, completed parallel word plus status out.
interface deser5bit_if;
    import deser5_pkg::*;

    // sin is consumed on any clock edge where sin_valid=1 and start=0 while a
    // frame is open; start always wins. word_valid/parity_err are one-cycle
    // strobes with no backpressure, so the receiver must take word on the strobe.
    logic              sin;
    logic              sin_valid;
    logic              start;
    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              parity_err;
    logic              busy;

    modport master (
        output sin, sin_valid, start,
        input  word, word_valid, parity_err, busy
    );

    modport slave (
        input  sin, sin_valid, start,
        output word, word_valid, parity_err, busy
    );

endinterface

// File: rtl/deser5bit.sv
// Collects a framed serial stream (start strobe, 5 data bits LSB first,
// optional even-parity bit) into a registered 5-bit word with a valid strobe.
module deser5bit
    import deser5_pkg::*;
#(
    parameter bit PARITY_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    deser5bit_if.slave  bus,
    output state_t      state_dbg
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [WORD_W-1:0] word_q;
    logic              word_valid_q;
    logic              parity_err_q;
    logic              emit;
    logic              perr_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            buf_q        <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            word_valid_q <= emit;
            parity_err_q <= emit & perr_d;
            if (emit) begin
                word_q <= buf_d;
            end
        end
    end

    // start overrides everything, including a data bit presented the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        emit    = 1'b0;
        perr_d  = 1'b0;
        if (bus.start) begin
            state_d = S_DATA;
            cnt_d   = '0;
            buf_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_DATA: begin
                    if (bus.sin_valid) begin
                        buf_d[cnt_q] = bus.sin;
                        cnt_d        = cnt_q + 3'd1;
                        if (cnt_q == CNT_W'(WORD_W - 1)) begin
                            cnt_d = '0;
                            if (PARITY_EN) begin
                                state_d = S_PAR;
                            end else begin
                                state_d = S_IDLE;
                                emit    = 1'b1;
                            end
                        end
                    end
                end
                S_PAR: begin
                    if (bus.sin_valid) begin
                        state_d = S_IDLE;
                        emit    = 1'b1;
                        perr_d  = even_par_err(buf_q, bus.sin);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.word       = word_q;
        bus.word_valid = word_valid_q;
        bus.parity_err = parity_err_q;
        bus.busy       = (state_q != S_IDLE);
        state_dbg      = state_q;
    end

endmodule

// File: doc/deser5bit.md
# deser5bit

Serial-to-parallel front end for the 5-bit datapath. It collects a framed serial bit stream (start strobe, 5 data bits LSB first, optional even-parity bit) and presents each completed frame as a 5-bit parallel word with a one-cycle `word_valid` strobe. The 5-bit parallel holding register downstream captures `word` on that strobe.

## Interface
- `PARITY_EN`, default 1: 1 means each frame carries a trailing even-parity bit; 0 means the frame is 5 data bits only.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sin`  in  1  serial data bit.
- `sin_valid`  in  1  `sin` is meaningful this cycle.
- `start`  in  1  frame-start strobe, one cycle.
- `word`  out  5  last completed data word, `word[0]` = first bit received.
- `word_valid`  out  1  one-cycle pulse: `word` was updated this cycle.
- `parity_err`  out  1  one-cycle pulse, coincident with `word_valid`, when parity failed.
- `busy`  out  1  high while a frame is in progress (state not IDLE).

## Operation
- States:
  - IDLE: waiting for `start`.
  - DATA: collecting data bits; a 3-bit count runs 0..4.
  - PARITY: collecting the parity bit; this state is used only when `PARITY_EN`=1.
- `start`=1 in any state:
  - Next state is DATA, count and shift buffer cleared.
  - The current frame is abandoned and no word is emitted.
  - A `sin_valid` bit in the same cycle is discarded (`start` wins).
- IDLE: `sin_valid` ignored.
- DATA, `sin_valid`=1, `start`=0:
  - `sin` is stored at buffer position [count], and count increments.
  - On count==4:
    - With `PARITY_EN`=1, go to PARITY.
    - With `PARITY_EN`=0, go to IDLE and emit the word.
- PARITY, `sin_valid`=1, `start`=0: go to IDLE and emit the word.
  - `parity_err` = XOR(data[4:0]) XOR `sin`, so an even total count of ones passes.
- `sin_valid`=0 in DATA or PARITY: state holds; gaps of any length are allowed, with no timeout.
- Emit:
  - `word` ← buffer.
  - `word_valid` ← 1 for exactly one cycle.
  - `parity_err` ← result, only when `PARITY_EN`=1; otherwise it is always 0.
  - The word is delivered even when parity fails.
- `word` holds its value between emits; it is never cleared except by reset.
- Reset values: state IDLE, count 0, buffer 0, `word` 5'b00000, `word_valid` 0, `parity_err` 0, `busy` 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Latency: the last bit of a frame is sampled at edge N, and `word`, `word_valid` and `parity_err` change at edge N, valid during cycle N→N+1.
- `word_valid` returns low at edge N+1 unless another frame completes there. That cannot happen, because a minimum frame is 6 cycles (start plus 5 bits).
- `start` sampled at edge N: `busy` is high from edge N.
- `busy` falls at the same edge `word_valid` rises.
- Back-to-back: `start` may arrive in the cycle directly after the emit; no dead cycle is required.
- `reset_n` low mid-frame: everything clears immediately (asynchronous) and no word is emitted. The first `start` after release begins a fresh frame.

## Structure
- Shared package `deser5_pkg`:
  - `WORD_W`=5.
  - State encoding constants `S_IDLE`=2'd0, `S_DATA`=2'd1, `S_PAR`=2'd2.
  - `CNT_W`=3.
- Single flat module; no sub-module is warranted. The FSM, the count and the buffer are small enough to share one sequential block plus next-state logic.
- Encoding 2'd3 is unreachable and recovers to IDLE.

## Test plan
- Reset then frame 5'b10110, `PARITY_EN`=1: pulse `start`, then `sin` = 0,1,1,0,1, then parity bit 1.
  - Required: `word`=5'b10110, one-cycle `word_valid`=1, `parity_err`=0, `busy` low after.
- Same frame with parity bit 0.
  - Required: `word`=5'b10110, `word_valid`=1, `parity_err`=1 in the same cycle.
- Frame 5'b00001 with 3 idle `sin_valid`=0 cycles between every bit.
  - Required: `word`=5'b00001 after the parity bit (1); `busy` held high throughout the gaps.
- Restart: `start`, 3 bits 1,1,1, then `start` again, then full frame 5'b01010 (parity 0).
  - Required: a single `word_valid` with `word`=5'b01010; no emit for the aborted frame.
- Reset mid-frame: `start`, 2 bits, then `reset_n` low for one cycle, then 3 more `sin_valid` bits.
  - Required: outputs at reset values, no `word_valid`, `busy`=0.
- `PARITY_EN`=0, frame 5'b11111.
  - Required: `word_valid` at the edge sampling the fifth bit, `word`=5'b11111, `parity_err`=0.
